// File: rtl/spi_flash_rom_reader_if.sv
// ROM-port and SPI-flash signal bundle for the program-ROM fetch stage.
`timescale 1ns/1ps
interface spi_flash_rom_reader_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic [7:0]        dout;
  logic              dready;
  logic              flash_cs;
  logic              flash_clk;
  logic              flash_mosi;
  logic              flash_miso;

  modport slave (
    input  addr, flash_miso,
    output dout, dready, flash_cs, flash_clk, flash_mosi
  );

  modport master (
    output addr, flash_miso,
    input  dout, dready, flash_cs, flash_clk, flash_mosi
  );
endinterface

// File: rtl/spi_flash_rom_reader.sv
// Program-ROM fetch stage: turns a CPU byte address into an SPI READ (0x03) of
// the external NOR flash, keeps CS low afterwards so that a request for the next
// sequential address streams one more byte without re-sending command/address.
`timescale 1ns/1ps
module spi_flash_rom_reader #(
  parameter int          ADDR_W      = 16,
  parameter logic [23:0] BASE_ADDR   = 24'h100000,
  parameter int          CLK_DIV     = 2,
  parameter int          CS_HIGH_MIN = 4,
  parameter int          HOLD_MAX    = 64
) (
  input logic                   clk,
  input logic                   rst,
  spi_flash_rom_reader_if.slave bus
);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int CSW_W  = $clog2(CS_HIGH_MIN + 1);
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD, DESEL} state_t;

  state_t              state, state_n;
  logic                cs, cs_n;
  logic                sck, sck_n;
  logic                valid, valid_n;
  logic                fin, fin_n;
  logic [7:0]          dout_r, dout_n;
  logic [7:0]          rx, rx_n;
  logic [31:0]         tx, tx_n;
  logic [4:0]          bit_cnt, bit_cnt_n;
  logic [DIV_W-1:0]    div_cnt, div_cnt_n;
  logic [CSW_W-1:0]    cs_wait, cs_wait_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic [ADDR_W-1:0]   served, served_n;
  logic [ADDR_W-1:0]   lat, lat_n;

  logic request, seq, abort;

  assign request = !valid || (bus.addr != served);
  // All-ones + 1 wraps the CPU address but not the flash address, so never stream across it.
  assign seq     = (bus.addr == served + ADDR_W'(1)) && (served != '1);
  assign abort   = (bus.addr != lat);

  assign bus.dout       = dout_r;
  assign bus.dready     = valid && (bus.addr == served);
  assign bus.flash_cs   = cs;
  assign bus.flash_clk  = sck;
  // tx shifts in zeros, so mosi is naturally low once command and address are out.
  assign bus.flash_mosi = tx[31];

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cs       <= 1'b1;
      sck      <= 1'b0;
      valid    <= 1'b0;
      fin      <= 1'b0;
      dout_r   <= '0;
      rx       <= '0;
      tx       <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      cs_wait  <= '0;
      hold_cnt <= '0;
      served   <= '0;
      lat      <= '0;
    end else begin
      state    <= state_n;
      cs       <= cs_n;
      sck      <= sck_n;
      valid    <= valid_n;
      fin      <= fin_n;
      dout_r   <= dout_n;
      rx       <= rx_n;
      tx       <= tx_n;
      bit_cnt  <= bit_cnt_n;
      div_cnt  <= div_cnt_n;
      cs_wait  <= cs_wait_n;
      hold_cnt <= hold_cnt_n;
      served   <= served_n;
      lat      <= lat_n;
    end
  end

  // Next-state, SPI bit timing and byte hand-off.
  always_comb begin
    state_n    = state;
    cs_n       = cs;
    sck_n      = sck;
    valid_n    = valid;
    fin_n      = fin;
    dout_n     = dout_r;
    rx_n       = rx;
    tx_n       = tx;
    bit_cnt_n  = bit_cnt;
    div_cnt_n  = div_cnt;
    cs_wait_n  = cs_wait;
    hold_cnt_n = hold_cnt;
    served_n   = served;
    lat_n      = lat;

    case (state)
      IDLE: begin
        cs_n  = 1'b1;
        sck_n = 1'b0;
        if (cs_wait != '0) begin
          cs_wait_n = cs_wait - 1'b1;
        end else if (request) begin
          state_n   = CMD;
          cs_n      = 1'b0;
          lat_n     = bus.addr;
          tx_n      = {8'h03, BASE_ADDR + 24'(bus.addr)};
          bit_cnt_n = 5'd7;
          div_cnt_n = DIV_LOAD;
          fin_n     = 1'b0;
        end
      end

      CMD, ADDR, DATA: begin
        if (abort) begin
          state_n = DESEL;
          cs_n    = 1'b1;
          sck_n   = 1'b0;
          tx_n    = '0;
          valid_n = 1'b0;
          fin_n   = 1'b0;
        end else if (fin) begin
          // One cycle after the last SCK fall: publish the byte.
          dout_n     = rx;
          served_n   = lat;
          valid_n    = 1'b1;
          fin_n      = 1'b0;
          hold_cnt_n = HOLD_W'(HOLD_MAX - 1);
          state_n    = HOLD;
        end else if (div_cnt != '0) begin
          div_cnt_n = div_cnt - 1'b1;
        end else begin
          div_cnt_n = DIV_LOAD;
          sck_n     = !sck;
          if (!sck) begin
            if (state == DATA) rx_n = {rx[6:0], bus.flash_miso};
          end else begin
            if (state != DATA) tx_n = {tx[30:0], 1'b0};
            if (bit_cnt != '0) begin
              bit_cnt_n = bit_cnt - 1'b1;
            end else if (state == CMD) begin
              state_n   = ADDR;
              bit_cnt_n = 5'd23;
            end else if (state == ADDR) begin
              state_n   = DATA;
              bit_cnt_n = 5'd7;
            end else begin
              fin_n = 1'b1;
            end
          end
        end
      end

      HOLD: begin
        sck_n = 1'b0;
        // A sequential request beats a simultaneous hold timeout.
        if (seq) begin
          state_n   = DATA;
          lat_n     = bus.addr;
          bit_cnt_n = 5'd7;
          div_cnt_n = DIV_LOAD;
          fin_n     = 1'b0;
        end else if (request || hold_cnt == '0) begin
          state_n = DESEL;
          cs_n    = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt - 1'b1;
        end
      end

      DESEL: begin
        cs_n      = 1'b1;
        sck_n     = 1'b0;
        cs_wait_n = CSW_W'(CS_HIGH_MIN);
        state_n   = IDLE;
      end

      default: begin
        state_n = IDLE;
        cs_n    = 1'b1;
        sck_n   = 1'b0;
      end
    endcase
  end
endmodule
